// File: rtl/window_scheduler.sv
// Frame sequencer for the 3x3 window generator: gates the raster source stream,
// forwards pixels one cycle later and reports the top-left coordinate of each interior window.
module window_scheduler #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset_FSM_n,
    input  logic          start,
    input  logic [DW-1:0] s_pixel,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] gen_pixel,
    output logic          gen_ren,
    output logic          gen_reset,
    output logic          win_valid,
    input  logic          win_ready,
    output logic [11:0]   win_row,
    output logic [11:0]   win_col,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, FLUSH} state_t;

    localparam logic [11:0] LAST_COL = 12'(IMG_W - 1);
    localparam logic [11:0] LAST_ROW = 12'(IMG_H - 1);

    state_t        state_q, state_d;
    logic [11:0]   row_q, row_d;
    logic [11:0]   col_q, col_d;
    logic [DW-1:0] gen_pixel_q, gen_pixel_d;
    logic          gen_ren_q, gen_ren_d;
    logic          win_valid_q, win_valid_d;
    logic [11:0]   win_row_q, win_row_d;
    logic [11:0]   win_col_q, win_col_d;
    logic          done_q, done_d;
    logic          accept;
    logic          win_hs;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        gen_pixel_d = gen_pixel_q;
        gen_ren_d   = 1'b0;
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        done_d      = 1'b0;
        s_ready     = 1'b0;
        accept      = 1'b0;
        win_hs      = win_valid_q && win_ready;

        if (win_hs) begin
            win_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                row_d       = 12'd0;
                col_d       = 12'd0;
                win_valid_d = 1'b0;
                state_d     = STREAM;
            end
            STREAM: begin
                // A pending window that is not being taken this cycle blocks the source.
                s_ready = !(win_valid_q && !win_ready);
                accept  = s_valid && s_ready;
                if (accept) begin
                    gen_ren_d   = 1'b1;
                    gen_pixel_d = s_pixel;
                    if (row_q >= 12'd2 && col_q >= 12'd2) begin
                        win_valid_d = 1'b1;
                        win_row_d   = row_q - 12'd2;
                        win_col_d   = col_q - 12'd2;
                    end
                    if (col_q == LAST_COL) begin
                        col_d = 12'd0;
                        row_d = row_q + 12'd1;
                    end else begin
                        col_d = col_q + 12'd1;
                    end
                    if (row_q == LAST_ROW && col_q == LAST_COL) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (win_hs) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_FSM_n) begin
        if (!reset_FSM_n) begin
            state_q     <= IDLE;
            row_q       <= 12'd0;
            col_q       <= 12'd0;
            gen_pixel_q <= '0;
            gen_ren_q   <= 1'b0;
            win_valid_q <= 1'b0;
            win_row_q   <= 12'd0;
            win_col_q   <= 12'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            gen_pixel_q <= gen_pixel_d;
            gen_ren_q   <= gen_ren_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            done_q      <= done_d;
        end
    end

    assign gen_pixel = gen_pixel_q;
    assign gen_ren   = gen_ren_q;
    assign gen_reset = (state_q == CLEAR);
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_window_scheduler.sv
// Scoreboard bench for window_scheduler: a 4x4 instance for the main scenarios
// and a 3x3 instance for the minimum-size frame.
module tb_window_scheduler;
    localparam int W     = 4;
    localparam int H     = 4;
    localparam int TOTAL = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, s_valid, win_ready;
    logic [31:0] s_pixel;
    logic        s_ready, gen_ren, gen_reset, win_valid, busy, done;
    logic [31:0] gen_pixel;
    logic [11:0] win_row, win_col;

    logic        rst3_n, start3, sv3, wr3;
    logic [31:0] px3;
    logic        sr3, gr3, grs3, wv3, busy3, done3;
    logic [31:0] gp3;
    logic [11:0] wrow3, wcol3;

    window_scheduler #(.IMG_W(W), .IMG_H(H), .DW(32)) dut (
        .clk(clk), .reset_FSM_n(rst_n), .start(start),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .gen_pixel(gen_pixel), .gen_ren(gen_ren), .gen_reset(gen_reset),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
    );

    window_scheduler #(.IMG_W(3), .IMG_H(3), .DW(32)) dut3 (
        .clk(clk), .reset_FSM_n(rst3_n), .start(start3),
        .s_pixel(px3), .s_valid(sv3), .s_ready(sr3),
        .gen_pixel(gp3), .gen_ren(gr3), .gen_reset(grs3),
        .win_valid(wv3), .win_ready(wr3),
        .win_row(wrow3), .win_col(wcol3), .busy(busy3), .done(done3)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pixq[$];
    logic [23:0] winq[$];
    logic [31:0] last_gen = 32'h0;

    task automatic begin_frame();
        start = 1'b1; s_valid = 1'b0; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (gen_reset !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0 || gen_ren !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_cycle: gen_reset=%b busy=%b s_ready=%b gen_ren=%b, required 1 1 0 0",
                     gen_reset, busy, s_ready, gen_ren);
        end
        @(posedge clk); #1;
        pixq.delete();
        winq.delete();
    endtask

    // vmode 1 toggles s_valid; rmode 1 holds win_ready low 3 cycles per window.
    task automatic stream_frame(input int vmode, input int rmode, input int start_cyc,
                                input int max_pix, output int n_win);
        int cyc = 0, acc_n = 0, hold = 0, mr = 0, mc = 0;
        bit prev_acc = 0, model_wv = 0, exp_done = 0, done_next = 0, fin = 0;
        bit acc, hs, flushing, exp_ready;
        logic [23:0] exp_w;
        n_win = 0;
        while (!fin && cyc < 500) begin
            s_valid = (acc_n < max_pix) && (vmode == 0 || (cyc % 2) == 0);
            s_pixel = 32'h3f000000 + (32'(acc_n) << 20);
            if (rmode == 1 && model_wv && hold < 3) begin
                win_ready = 1'b0;
                hold++;
            end else begin
                win_ready = 1'b1;
            end
            start = (cyc == start_cyc);
            #1;
            exp_done  = done_next;
            flushing  = (acc_n == TOTAL);
            exp_ready = !flushing && !exp_done && !(model_wv && !win_ready);

            n_cmp++;
            if (gen_ren !== prev_acc) begin
                n_bad++;
                $display("FAIL gen_ren cyc%0d: got %b expected %b", cyc, gen_ren, prev_acc);
            end
            if (prev_acc) last_gen = pixq.pop_front();
            n_cmp++;
            if (gen_pixel !== last_gen) begin
                n_bad++;
                $display("FAIL gen_pixel cyc%0d: got %h expected %h", cyc, gen_pixel, last_gen);
            end
            n_cmp++;
            if (s_ready !== exp_ready) begin
                n_bad++;
                $display("FAIL s_ready cyc%0d: got %b expected %b", cyc, s_ready, exp_ready);
            end
            n_cmp++;
            if (win_valid !== model_wv) begin
                n_bad++;
                $display("FAIL win_valid cyc%0d: got %b expected %b", cyc, win_valid, model_wv);
            end
            if (model_wv && winq.size() > 0) begin
                n_cmp++;
                if ({win_row, win_col} !== winq[0]) begin
                    n_bad++;
                    $display("FAIL win_coord cyc%0d: got (%0d,%0d) expected (%0d,%0d)", cyc,
                             win_row, win_col, winq[0][23:12], winq[0][11:0]);
                end
            end
            n_cmp++;
            if (done !== exp_done || busy !== !exp_done || gen_reset !== 1'b0) begin
                n_bad++;
                $display("FAIL status cyc%0d: done=%b busy=%b gen_reset=%b, expected done=%b busy=%b gen_reset=0",
                         cyc, done, busy, gen_reset, exp_done, !exp_done);
            end
            if (exp_done) fin = 1;

            acc       = s_valid && exp_ready;
            hs        = model_wv && win_ready;
            done_next = hs && flushing;
            if (hs) begin
                exp_w    = winq.pop_front();
                n_win++;
                model_wv = 0;
                hold     = 0;
            end
            if (acc) begin
                pixq.push_back(s_pixel);
                if (mr >= 2 && mc >= 2) begin
                    winq.push_back({12'(mr - 2), 12'(mc - 2)});
                    model_wv = 1;
                end
                if (mc == W - 1) begin
                    mc = 0;
                    mr++;
                end else begin
                    mc++;
                end
                acc_n++;
            end
            prev_acc = acc;
            cyc++;
            @(posedge clk); #1;
            if (max_pix < TOTAL && acc_n == max_pix) fin = 1;
        end
        s_valid = 1'b0; start = 1'b0; win_ready = 1'b1;
        if (!fin) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_timeout: got %0d pixels accepted, required %0d", acc_n, max_pix);
        end
    endtask

    task automatic check_windows(input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL window_count: got %0d expected %0d", got, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; s_valid = 1'b1; win_ready = 1'b0; s_pixel = 32'hdeadbeef;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({s_ready, gen_ren, gen_reset, win_valid, busy, done} !== 6'b0 ||
            gen_pixel !== 32'h0 || win_row !== 12'h0 || win_col !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got ctl=%b pix=%h row=%0d col=%0d, required all 0",
                     {s_ready, gen_ren, gen_reset, win_valid, busy, done}, gen_pixel, win_row, win_col);
        end
        start = 1'b0; s_valid = 1'b0; win_ready = 1'b1;
        rst_n = 1'b1; rst3_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || busy3 !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy=%b busy3=%b, required 0 0", busy, busy3);
        end
        last_gen = 32'h0;
    endtask

    task automatic test_basic();
        int nw;
        begin_frame();
        stream_frame(0, 0, -1, TOTAL, nw);
        check_windows(nw, (H - 2) * (W - 2));
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL done_width: done=%b busy=%b one cycle after pulse, required 0 0", done, busy);
        end
    endtask

    task automatic test_backpressure();
        int nw;
        begin_frame();
        stream_frame(0, 1, -1, TOTAL, nw);
        check_windows(nw, (H - 2) * (W - 2));
    endtask

    task automatic test_valid_toggle();
        int nw;
        begin_frame();
        stream_frame(1, 0, -1, TOTAL, nw);
        check_windows(nw, (H - 2) * (W - 2));
    endtask

    task automatic test_start_ignored();
        int nw;
        begin_frame();
        stream_frame(0, 1, 5, TOTAL, nw);
        check_windows(nw, (H - 2) * (W - 2));
    endtask

    task automatic test_abort();
        int nw;
        begin_frame();
        stream_frame(0, 0, -1, 7, nw);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({s_ready, gen_ren, gen_reset, win_valid, busy, done} !== 6'b0 ||
            gen_pixel !== 32'h0 || win_row !== 12'h0 || win_col !== 12'h0) begin
            n_bad++;
            $display("FAIL abort_outputs: got ctl=%b pix=%h row=%0d col=%0d, required all 0",
                     {s_ready, gen_ren, gen_reset, win_valid, busy, done}, gen_pixel, win_row, win_col);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_gen = 32'h0;
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: done=%b busy=%b, required 0 0", done, busy);
        end
        begin_frame();
        stream_frame(0, 0, -1, TOTAL, nw);
        check_windows(nw, (H - 2) * (W - 2));
    endtask

    task automatic test_small();
        int n = 0, wins = 0, cyc = 0;
        bit prev_acc = 0, model_wv = 0, done_next = 0, exp_done = 0, fin = 0, acc;
        logic [31:0] exp_p = 32'h0;
        logic [23:0] wq[$];
        logic [23:0] w;
        wr3 = 1'b1; sv3 = 1'b0; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        n_cmp++;
        if (grs3 !== 1'b1) begin
            n_bad++;
            $display("FAIL small_clear: gen_reset=%b expected 1", grs3);
        end
        @(posedge clk); #1;
        while (!fin && cyc < 60) begin
            sv3 = (n < 9);
            px3 = 32'h40000000 + 32'(n);
            #1;
            exp_done = done_next;
            n_cmp++;
            if (sr3 !== (n < 9) || gr3 !== prev_acc || done3 !== exp_done) begin
                n_bad++;
                $display("FAIL small_ctl cyc%0d: s_ready=%b gen_ren=%b done=%b, expected %b %b %b",
                         cyc, sr3, gr3, done3, (n < 9), prev_acc, exp_done);
            end
            if (prev_acc) begin
                n_cmp++;
                if (gp3 !== exp_p) begin
                    n_bad++;
                    $display("FAIL small_pixel cyc%0d: got %h expected %h", cyc, gp3, exp_p);
                end
            end
            n_cmp++;
            if (wv3 !== model_wv || (model_wv && {wrow3, wcol3} !== wq[0])) begin
                n_bad++;
                $display("FAIL small_window cyc%0d: valid=%b (%0d,%0d), expected valid=%b (0,0)",
                         cyc, wv3, wrow3, wcol3, model_wv);
            end
            if (exp_done) fin = 1;
            acc       = (n < 9);
            done_next = model_wv && (n == 9);
            if (model_wv) begin
                w = wq.pop_front();
                wins++;
                model_wv = 0;
            end
            if (acc) begin
                exp_p = px3;
                if (n == 8) begin
                    wq.push_back(24'h0);
                    model_wv = 1;
                end
                n++;
            end
            prev_acc = acc;
            cyc++;
            @(posedge clk); #1;
        end
        sv3 = 1'b0;
        n_cmp++;
        if (!fin || wins != 1) begin
            n_bad++;
            $display("FAIL small_frame: done_seen=%b windows=%0d, required 1 and 1", fin, wins);
        end
    endtask

    initial begin
        rst_n = 1'b0; rst3_n = 1'b0;
        start = 1'b0; s_valid = 1'b0; win_ready = 1'b1; s_pixel = 32'h0;
        start3 = 1'b0; sv3 = 1'b0; wr3 = 1'b1; px3 = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_valid_toggle();
        test_start_ignored();
        test_abort();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
